// File: rtl/cache_fill_fsm.sv
// Block-fill miss handler for the 2-way data cache: fetches an 8-word block, writes it, then metadata.
// Outputs are combinational from state/counters/MemDataValid; memory returns are never stalled.
module cache_fill_fsm #(
   parameter int WORDS  = 8,
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              Req,
   input  logic              Miss,
   input  logic [ADDR_W-1:0] MissAddr,
   input  logic [ADDR_W-1:0] MemDataIn,
   input  logic              MemDataValid,
   output logic [ADDR_W-1:0] MemAddr,
   output logic              MemEnable,
   output logic [ADDR_W-1:0] FillAddr,
   output logic [ADDR_W-1:0] DataOut_FSM,
   output logic              Data_WE,
   output logic              MetaData_WE,
   output logic              Busy
);

   localparam int CNT_W = $clog2(WORDS);
   localparam int OFF_W = CNT_W + 1;
   localparam logic [CNT_W-1:0]  LAST     = CNT_W'(WORDS - 1);
   localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      META = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
   logic [CNT_W-1:0]  recv_cnt_q, recv_cnt_d;
   logic              issue_done_q, issue_done_d;

   function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [CNT_W-1:0]  cnt);
      return base + {{(ADDR_W-OFF_W){1'b0}}, cnt, 1'b0};
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         base_q       <= '0;
         issue_cnt_q  <= '0;
         recv_cnt_q   <= '0;
         issue_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         base_q       <= base_d;
         issue_cnt_q  <= issue_cnt_d;
         recv_cnt_q   <= recv_cnt_d;
         issue_done_q <= issue_done_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      base_d       = base_q;
      issue_cnt_d  = issue_cnt_q;
      recv_cnt_d   = recv_cnt_q;
      issue_done_d = issue_done_q;
      case (state_q)
         IDLE: begin
            if (Req && Miss) begin
               state_d      = FILL;
               base_d       = MissAddr & ~OFF_MASK;
               issue_cnt_d  = '0;
               recv_cnt_d   = '0;
               issue_done_d = 1'b0;
            end
         end
         FILL: begin
            // Issue and receive counters advance independently; returns lag issues.
            if (!issue_done_q) begin
               issue_cnt_d = issue_cnt_q + 1'b1;
               if (issue_cnt_q == LAST) begin
                  issue_done_d = 1'b1;
               end
            end
            if (MemDataValid) begin
               recv_cnt_d = recv_cnt_q + 1'b1;
               if (recv_cnt_q == LAST) begin
                  state_d = META;
               end
            end
         end
         META:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      MemAddr     = '0;
      MemEnable   = 1'b0;
      FillAddr    = '0;
      DataOut_FSM = '0;
      Data_WE     = 1'b0;
      MetaData_WE = 1'b0;
      Busy        = 1'b0;
      case (state_q)
         FILL: begin
            Busy      = 1'b1;
            MemEnable = !issue_done_q;
            MemAddr   = word_addr(base_q, issue_cnt_q);
            FillAddr  = base_q;
            if (MemDataValid) begin
               Data_WE     = 1'b1;
               DataOut_FSM = MemDataIn;
               FillAddr    = word_addr(base_q, recv_cnt_q);
            end
         end
         META: begin
            // Metadata (and LRU) only updates after every data word is in place.
            Busy        = 1'b1;
            MetaData_WE = 1'b1;
            FillAddr    = base_q;
         end
         default: ;
      endcase
   end

endmodule
